// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared types and helpers for the pulse counter
package pulse_pkg;

  typedef enum logic {ST_RUN, ST_DONE} pulse_state_t;

  // All-ones value for a counter of the given width (widths up to 16)
  function automatic logic [15:0] cnt_max(input int unsigned bits);
    return 16'((32'd1 << bits) - 32'd1);
  endfunction

endpackage

// File: rtl/pulse_evt_cnt.sv
// rtl/pulse_evt_cnt.sv - saturating event counter, cleared only by reset
module pulse_evt_cnt #(
  parameter int P_EVT_BIT = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 inc,
  output logic [P_EVT_BIT-1:0] value
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + P_EVT_BIT'(1);
    end
  end

endmodule

// File: rtl/pulse_counter.sv
// rtl/pulse_counter.sv - loadable up-counter with wrap pulse, event count and one-shot mode
module pulse_counter
  import pulse_pkg::*;
#(
  parameter int P_BIT     = 4,
  parameter int P_ONESHOT = 0,
  parameter int P_EVT_BIT = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 wenable,
  input  logic [P_BIT-1:0]     wcount,
  output logic [P_BIT-1:0]     count,
  output logic                 carry,
  output logic [P_EVT_BIT-1:0] carry_cnt,
  output logic                 done
);

  localparam logic [P_BIT-1:0] CNT_MAX = P_BIT'(cnt_max(P_BIT));

  pulse_state_t state;
  logic         done_q;
  logic         wrap;

  // A load in the same cycle as max->0 suppresses the wrap entirely
  assign wrap = !wenable && enable && (state == ST_RUN) && (count == CNT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_RUN;
      count  <= '0;
      carry  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      carry <= wrap;
      if (wenable) begin
        count  <= wcount;
        state  <= ST_RUN;
        done_q <= 1'b0;
      end else if (enable && (state == ST_RUN)) begin
        count <= count + P_BIT'(1);
        if ((P_ONESHOT != 0) && (count == CNT_MAX)) begin
          state  <= ST_DONE;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = (P_ONESHOT != 0) ? done_q : 1'b0;

  pulse_evt_cnt #(
    .P_EVT_BIT(P_EVT_BIT)
  ) u_evt_cnt (
    .clk   (clk),
    .resetn(resetn),
    .inc   (wrap),
    .value (carry_cnt)
  );

endmodule

// File: tb/tb_pulse_counter.sv
// tb/tb_pulse_counter.sv - randomized bench for pulse_counter against a behavioural model
module tb_pulse_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       en  [3];
  logic       we  [3];
  logic [3:0] wc  [3];
  logic [3:0] cnt [3];
  logic       car [3];
  logic       dn  [3];
  logic [15:0] cc_a, cc_b;
  logic [1:0]  cc_c;

  // 0: free-running, 1: one-shot, 2: free-running with 2-bit event counter
  pulse_counter #(.P_BIT(4), .P_ONESHOT(0), .P_EVT_BIT(16)) dut_a (
    .clk(clk), .resetn(resetn), .enable(en[0]), .wenable(we[0]), .wcount(wc[0]),
    .count(cnt[0]), .carry(car[0]), .carry_cnt(cc_a), .done(dn[0]));
  pulse_counter #(.P_BIT(4), .P_ONESHOT(1), .P_EVT_BIT(16)) dut_b (
    .clk(clk), .resetn(resetn), .enable(en[1]), .wenable(we[1]), .wcount(wc[1]),
    .count(cnt[1]), .carry(car[1]), .carry_cnt(cc_b), .done(dn[1]));
  pulse_counter #(.P_BIT(4), .P_ONESHOT(0), .P_EVT_BIT(2)) dut_c (
    .clk(clk), .resetn(resetn), .enable(en[2]), .wenable(we[2]), .wcount(wc[2]),
    .count(cnt[2]), .carry(car[2]), .carry_cnt(cc_c), .done(dn[2]));

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt [3];
  int m_car [3];
  int m_evt [3];
  int m_done[3];
  int m_stop[3];
  int evt_max[3] = '{65535, 65535, 3};
  int oneshot[3] = '{0, 1, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] cc_val(input int i);
    case (i)
      0:       return {16'b0, cc_a};
      1:       return {16'b0, cc_b};
      default: return {30'b0, cc_c};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_car[i] = 0; m_evt[i] = 0; m_done[i] = 0; m_stop[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (we[i]) begin
        m_cnt[i] = int'(wc[i]); m_car[i] = 0; m_done[i] = 0; m_stop[i] = 0;
      end else if (en[i] && (m_stop[i] == 0)) begin
        m_car[i] = (m_cnt[i] == 15) ? 1 : 0;
        m_cnt[i] = (m_cnt[i] + 1) % 16;
        if (m_car[i] != 0) begin
          if (m_evt[i] < evt_max[i]) m_evt[i]++;
          if (oneshot[i] != 0) begin
            m_stop[i] = 1; m_done[i] = 1;
          end
        end
      end else begin
        m_car[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("count%0d", i), {28'b0, cnt[i]}, m_cnt[i]);
      check($sformatf("carry%0d", i), {31'b0, car[i]}, m_car[i]);
      check($sformatf("carry_cnt%0d", i), cc_val(i), m_evt[i]);
      check($sformatf("done%0d", i), {31'b0, dn[i]}, m_done[i]);
    end
  endtask

  task automatic drive(input logic e, input logic w, input logic [3:0] v);
    for (int i = 0; i < 3; i++) begin
      en[i] = e; we[i] = w; wc[i] = v;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b0, 1'b0, 4'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    resetn = 1'b1;

    // Free run through a full wrap
    drive(1'b1, 1'b0, 4'd0);
    repeat (20) step();

    // Load 14 then count across the wrap
    drive(1'b1, 1'b1, 4'd14);
    step();
    drive(1'b1, 1'b0, 4'd0);
    repeat (4) step();

    // Load at max colliding with an increment
    drive(1'b0, 1'b1, 4'd15);
    step();
    drive(1'b1, 1'b1, 4'd5);
    step();
    drive(1'b0, 1'b0, 4'd0);
    step();

    // One-shot: load 13, run into DONE, reload 2
    drive(1'b1, 1'b1, 4'd13);
    step();
    drive(1'b1, 1'b0, 4'd0);
    repeat (6) step();
    drive(1'b1, 1'b1, 4'd2);
    step();
    drive(1'b1, 1'b0, 4'd0);
    repeat (3) step();

    // Five wraps from zero to exercise event counter saturation
    drive(1'b1, 1'b1, 4'd0);
    step();
    drive(1'b1, 1'b0, 4'd0);
    repeat (80) step();

    repeat (400) begin
      for (int i = 0; i < 3; i++) begin
        en[i] = ($urandom_range(0, 3) != 0);
        we[i] = ($urandom_range(0, 9) == 0);
        wc[i] = 4'($urandom);
      end
      step();
    end

    // Asynchronous reset mid-cycle while at max with enable high
    drive(1'b1, 1'b1, 4'd15);
    step();
    drive(1'b1, 1'b0, 4'd0);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    resetn = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
